// File: rtl/exe_mem_req.sv
// Execute-stage memory request issue: latches one instruction, drives the data SRAM
// request and tracks live and flushed-away responses. Optional alignment check: EXE_ALE_CHECK_EN.
module exe_mem_req (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_load_op,   // {lhu,lbu,lw,lh,lb}
  input  logic [2:0]  in_store_op,  // {sw,sh,sb}
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        in_ex,
  input  logic        flush,
  input  logic        ms_allowin,
  output logic        out_valid,
  output logic        out_mem_req,
  output logic        out_ale,
  output logic        out_ex,
  output logic [31:0] out_vaddr,
  output logic        out_rdata_vld,
  output logic [31:0] out_rdata,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        ms_data_ok
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_PASS} state_t;

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic        mem_req_q, mem_req_d;
  logic        rdata_vld_q, rdata_vld_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  live_q, live_d;
  logic [1:0]  discard_q, discard_d;
  logic [4:0]  load_q;
  logic [2:0]  store_q;
  logic [31:0] addr_q, wdata_q;
  logic        ex_q, ale_q;

  logic in_is_mem, in_ale, req, req_acc, ready_go, accept, pass;
  logic discard_hit, live_ret, capture;
  logic op_byte, op_half, op_word;

  assign in_is_mem = (|in_load_op) | (|in_store_op);
`ifdef EXE_ALE_CHECK_EN
  assign in_ale = ((in_load_op[1] | in_load_op[4] | in_store_op[1]) & in_addr[0])
                | ((in_load_op[2] | in_store_op[2]) & (|in_addr[1:0]));
`else
  assign in_ale = 1'b0;
`endif

  assign req         = (state_q == S_ISSUE) && !flush && !reset && (live_q < 2'd2);
  assign req_acc     = req & data_sram_addr_ok;
  assign discard_hit = data_sram_data_ok & (discard_q != 2'd0);
  assign live_ret    = data_sram_data_ok & (discard_q == 2'd0);
  // Capture only if the instruction stays here; on a same-cycle handoff the
  // response goes straight through to the memory stage instead.
  assign capture = live_ret && (state_q == S_WAIT) && (live_q == 2'd1) && !ms_allowin && !flush;

  always_comb begin
    ready_go = 1'b0;
    case (state_q)
      S_ISSUE:         ready_go = req_acc;
      S_WAIT, S_PASS:  ready_go = 1'b1;
      default:         ready_go = 1'b0;
    endcase
  end

  assign in_ready  = !valid_q | (ready_go & ms_allowin);
  assign accept    = in_valid & in_ready & !flush;
  assign pass      = valid_q & ready_go & ms_allowin & !flush;
  assign out_valid = valid_q & ready_go & !flush & !reset;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    mem_req_d   = mem_req_q;
    rdata_vld_d = rdata_vld_q;
    rdata_d     = rdata_q;
    live_d      = live_q + {1'b0, req_acc} - {1'b0, live_ret};
    discard_d   = discard_q - {1'b0, discard_hit};
    if (flush) begin
      state_d     = S_IDLE;
      valid_d     = 1'b0;
      mem_req_d   = 1'b0;
      rdata_vld_d = 1'b0;
      live_d      = 2'd0;
      discard_d   = discard_q - {1'b0, discard_hit} + (live_q - {1'b0, live_ret});
    end else begin
      if (req_acc) mem_req_d = 1'b1;
      if (capture) begin
        rdata_vld_d = 1'b1;
        rdata_d     = data_sram_rdata;
      end
      if (pass) begin
        state_d     = S_IDLE;
        valid_d     = 1'b0;
        mem_req_d   = 1'b0;
        rdata_vld_d = 1'b0;
      end else if (state_q == S_ISSUE && req_acc) begin
        state_d = S_WAIT;
      end
      if (accept) begin
        valid_d     = 1'b1;
        mem_req_d   = 1'b0;
        rdata_vld_d = 1'b0;
        state_d     = (in_is_mem && !in_ex && !in_ale) ? S_ISSUE : S_PASS;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      valid_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      rdata_vld_q <= 1'b0;
      rdata_q     <= 32'd0;
      live_q      <= 2'd0;
      discard_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      mem_req_q   <= mem_req_d;
      rdata_vld_q <= rdata_vld_d;
      rdata_q     <= rdata_d;
      live_q      <= live_d;
      discard_q   <= discard_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      load_q  <= in_load_op;
      store_q <= in_store_op;
      addr_q  <= in_addr;
      wdata_q <= in_wdata;
      ex_q    <= in_ex;
      ale_q   <= in_ale;
    end
  end

  assign op_byte = load_q[0] | load_q[3] | store_q[0];
  assign op_half = load_q[1] | load_q[4] | store_q[1];
  assign op_word = load_q[2] | store_q[2];

  always_comb begin
    data_sram_wstrb = 4'b0000;
    data_sram_wdata = wdata_q;
    if (store_q[0]) begin
      data_sram_wstrb = 4'b0001 << addr_q[1:0];
      data_sram_wdata = {4{wdata_q[7:0]}};
    end else if (store_q[1]) begin
      data_sram_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
      data_sram_wdata = {2{wdata_q[15:0]}};
    end else if (store_q[2]) begin
      data_sram_wstrb = 4'b1111;
    end
  end

  assign data_sram_req  = req;
  assign data_sram_wr   = |store_q;
  assign data_sram_size = op_word ? 2'd2 : (op_half ? 2'd1 : (op_byte ? 2'd0 : 2'd0));
  assign data_sram_addr = addr_q;
  assign ms_data_ok     = live_ret & !capture & !reset;
  assign out_mem_req    = mem_req_q | req_acc;
  assign out_ale        = ale_q;
  assign out_ex         = ex_q | ale_q;
  assign out_vaddr      = addr_q;
  assign out_rdata_vld  = rdata_vld_q;
  assign out_rdata      = rdata_q;

endmodule

// File: tb/tb_exe_mem_req.sv
// Scoreboard bench for exe_mem_req: directed ops push expected SRAM requests,
// stage handoffs and ms_data_ok pulses; a negedge monitor pops and compares.
module tb_exe_mem_req;

  logic        clk, reset, in_valid, in_ready, in_ex, flush, ms_allowin;
  logic [4:0]  in_load_op;
  logic [2:0]  in_store_op;
  logic [31:0] in_addr, in_wdata;
  logic        out_valid, out_mem_req, out_ale, out_ex, out_rdata_vld;
  logic [31:0] out_vaddr, out_rdata;
  logic        data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok, ms_data_ok;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;

  exe_mem_req dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_load_op(in_load_op), .in_store_op(in_store_op), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_ex(in_ex), .flush(flush), .ms_allowin(ms_allowin),
    .out_valid(out_valid), .out_mem_req(out_mem_req), .out_ale(out_ale), .out_ex(out_ex),
    .out_vaddr(out_vaddr), .out_rdata_vld(out_rdata_vld), .out_rdata(out_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .ms_data_ok(ms_data_ok)
  );

  typedef struct {
    logic [31:0] addr; logic wr; logic [1:0] size; logic [3:0] wstrb; logic [31:0] wdata;
  } req_t;
  typedef struct {
    logic [31:0] vaddr; logic mem_req; logic ale; logic ex; logic vld; logic [31:0] rdata;
  } out_t;

  req_t exp_req[$];
  out_t exp_out[$];
  int   exp_msok;
  int   n_vec, n_miss;
  req_t r;
  out_t o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic push_req(input logic [31:0] a, input logic wr, input logic [1:0] sz,
                          input logic [3:0] st, input logic [31:0] wd);
    req_t t;
    t.addr = a; t.wr = wr; t.size = sz; t.wstrb = st; t.wdata = wd;
    exp_req.push_back(t);
  endtask

  task automatic push_out(input logic [31:0] a, input logic mr, input logic ale,
                          input logic ex, input logic vld, input logic [31:0] rd);
    out_t t;
    t.vaddr = a; t.mem_req = mr; t.ale = ale; t.ex = ex; t.vld = vld; t.rdata = rd;
    exp_out.push_back(t);
  endtask

  task automatic drive(input logic [4:0] l, input logic [2:0] s, input logic [31:0] a,
                       input logic [31:0] w, input logic ex);
    in_valid = 1'b1; in_load_op = l; in_store_op = s; in_addr = a; in_wdata = w; in_ex = ex;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_load_op = 5'd0; in_store_op = 3'd0; in_ex = 1'b0;
  endtask

  // One op, addr_ok and ms_allowin held high, response returned two cycles later.
  task automatic simple_op(input logic [4:0] l, input logic [2:0] s, input logic [31:0] a,
                           input logic [31:0] w);
    cyc(); drive(l, s, a, w, 1'b0); data_sram_addr_ok = 1'b1; ms_allowin = 1'b1;
    cyc(); idle_in();
    cyc(); data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; exp_msok++;
    cyc(); data_sram_data_ok = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (data_sram_req && data_sram_addr_ok) begin
        if (exp_req.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL unexpected_req: got addr %h expected no request", data_sram_addr);
        end else begin
          r = exp_req.pop_front();
          check("req_addr", data_sram_addr, r.addr);
          check("req_wr", {31'd0, data_sram_wr}, {31'd0, r.wr});
          check("req_size", {30'd0, data_sram_size}, {30'd0, r.size});
          check("req_wstrb", {28'd0, data_sram_wstrb}, {28'd0, r.wstrb});
          if (r.wr) check("req_wdata", data_sram_wdata, r.wdata);
        end
      end
      if (out_valid && ms_allowin) begin
        if (exp_out.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL unexpected_handoff: got vaddr %h expected none", out_vaddr);
        end else begin
          o = exp_out.pop_front();
          check("out_vaddr", out_vaddr, o.vaddr);
          check("out_mem_req", {31'd0, out_mem_req}, {31'd0, o.mem_req});
          check("out_ale", {31'd0, out_ale}, {31'd0, o.ale});
          check("out_ex", {31'd0, out_ex}, {31'd0, o.ex});
          check("out_rdata_vld", {31'd0, out_rdata_vld}, {31'd0, o.vld});
          if (o.vld) check("out_rdata", out_rdata, o.rdata);
        end
      end
      if (ms_data_ok) begin
        n_vec++;
        if (exp_msok == 0) begin
          n_miss++;
          $display("FAIL unexpected_ms_data_ok: got 1 expected 0");
        end else exp_msok--;
      end
    end
  end

  initial begin
    n_vec = 0; n_miss = 0; exp_msok = 0;
    reset = 1'b1; flush = 1'b0; ms_allowin = 1'b0; in_addr = 32'd0; in_wdata = 32'd0;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0;
    idle_in();
    cyc(); cyc();
    at_neg();
    check("rst_req", {31'd0, data_sram_req}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_rdata_vld", {31'd0, out_rdata_vld}, 32'd0);
    check("rst_rdata", out_rdata, 32'd0);
    check("rst_ms_data_ok", {31'd0, ms_data_ok}, 32'd0);
    cyc(); reset = 1'b0;
    at_neg();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // sw / sb / sh / lbu single ops
    push_req(32'h1000, 1'b1, 2'd2, 4'b1111, 32'hDEADBEEF);
    push_out(32'h1000, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    simple_op(5'd0, 3'b100, 32'h1000, 32'hDEADBEEF);
    push_req(32'h1003, 1'b1, 2'd0, 4'b1000, 32'h5A5A5A5A);
    push_out(32'h1003, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    simple_op(5'd0, 3'b001, 32'h1003, 32'h0000005A);
    push_req(32'h2002, 1'b1, 2'd1, 4'b1100, 32'hBEEFBEEF);
    push_out(32'h2002, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    simple_op(5'd0, 3'b010, 32'h2002, 32'h1234BEEF);
    push_req(32'h0011, 1'b0, 2'd0, 4'b0000, 32'd0);
    push_out(32'h0011, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    simple_op(5'b01000, 3'd0, 32'h0011, 32'd0);

    // lw held in WAIT: response captured locally
    cyc(); drive(5'b00100, 3'd0, 32'h2000, 32'd0, 1'b0); data_sram_addr_ok = 1'b1; ms_allowin = 1'b0;
    push_req(32'h2000, 1'b0, 2'd2, 4'b0000, 32'd0);
    cyc(); idle_in();
    cyc(); data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h12345678;
    cyc(); data_sram_data_ok = 1'b0;
    at_neg();
    check("wait_rdata_vld", {31'd0, out_rdata_vld}, 32'd1);
    check("wait_rdata", out_rdata, 32'h12345678);
    cyc(); ms_allowin = 1'b1; push_out(32'h2000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h12345678);
    cyc();
    at_neg();
    check("vld_clear_on_pass", {31'd0, out_rdata_vld}, 32'd0);

    // flush with one response outstanding; it must be swallowed
    cyc(); drive(5'b00100, 3'd0, 32'h2004, 32'd0, 1'b0); data_sram_addr_ok = 1'b1; ms_allowin = 1'b0;
    push_req(32'h2004, 1'b0, 2'd2, 4'b0000, 32'd0);
    cyc(); idle_in();
    cyc(); data_sram_addr_ok = 1'b0; flush = 1'b1;
    at_neg();
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    cyc(); flush = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBAD0BAD0;
    cyc(); data_sram_data_ok = 1'b0;
    // a following lw is captured only if discard and live counts are back to 0/1
    cyc(); drive(5'b00100, 3'd0, 32'h2008, 32'd0, 1'b0); data_sram_addr_ok = 1'b1;
    push_req(32'h2008, 1'b0, 2'd2, 4'b0000, 32'd0);
    cyc(); idle_in();
    cyc(); data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAABBCCDD;
    cyc(); data_sram_data_ok = 1'b0;
    at_neg();
    check("post_flush_capture", {31'd0, out_rdata_vld}, 32'd1);
    cyc(); ms_allowin = 1'b1; push_out(32'h2008, 1'b1, 1'b0, 1'b0, 1'b1, 32'hAABBCCDD);
    cyc();

    // flush while ISSUE request is pending: no request in the flush cycle
    cyc(); drive(5'b00100, 3'd0, 32'h2010, 32'd0, 1'b0); ms_allowin = 1'b0;
    cyc(); idle_in();
    at_neg();
    check("issue_req_high", {31'd0, data_sram_req}, 32'd1);
    cyc(); flush = 1'b1;
    at_neg();
    check("flush_req_low", {31'd0, data_sram_req}, 32'd0);
    cyc(); flush = 1'b0;
    at_neg();
    check("after_flush_req", {31'd0, data_sram_req}, 32'd0);

    // reset during ISSUE with addr_ok low
    cyc(); drive(5'b00100, 3'd0, 32'h2020, 32'd0, 1'b0);
    cyc(); idle_in();
    cyc(); reset = 1'b1;
    at_neg();
    check("reset_cycle_req", {31'd0, data_sram_req}, 32'd0);
    cyc(); reset = 1'b0;
    at_neg();
    check("post_reset_req", {31'd0, data_sram_req}, 32'd0);
    check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

    // misaligned lh
`ifdef EXE_ALE_CHECK_EN
    push_out(32'h3001, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    cyc(); drive(5'b00010, 3'd0, 32'h3001, 32'd0, 1'b0); data_sram_addr_ok = 1'b1; ms_allowin = 1'b1;
    cyc(); idle_in();
    cyc(); cyc(); data_sram_addr_ok = 1'b0;
`else
    push_req(32'h3001, 1'b0, 2'd1, 4'b0000, 32'd0);
    push_out(32'h3001, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    simple_op(5'b00010, 3'd0, 32'h3001, 32'd0);
`endif

    // upstream exception and a non-memory op both bypass the SRAM
    push_out(32'h4000, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    cyc(); drive(5'b00100, 3'd0, 32'h4000, 32'd0, 1'b1); data_sram_addr_ok = 1'b1; ms_allowin = 1'b1;
    cyc(); idle_in();
    push_out(32'h4444, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc(); drive(5'd0, 3'd0, 32'h4444, 32'd0, 1'b0);
    cyc(); idle_in();
    cyc(); data_sram_addr_ok = 1'b0;

    // back-to-back stores, two responses outstanding
    push_req(32'h5000, 1'b1, 2'd2, 4'b1111, 32'h11111111);
    push_out(32'h5000, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    push_req(32'h5006, 1'b1, 2'd1, 4'b1100, 32'h22332233);
    push_out(32'h5006, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc(); drive(5'd0, 3'b100, 32'h5000, 32'h11111111, 1'b0); data_sram_addr_ok = 1'b1;
    cyc(); drive(5'd0, 3'b010, 32'h5006, 32'h99002233, 1'b0);
    cyc(); idle_in();
    cyc(); data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; exp_msok += 2;
    cyc(); cyc(); data_sram_data_ok = 1'b0;
    cyc(); cyc();

    check("req_queue_drained", exp_req.size(), 32'd0);
    check("out_queue_drained", exp_out.size(), 32'd0);
    check("msok_drained", exp_msok, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/exe_mem_req.md
EXE_MEM_REQ -- requirements
Module: exe_mem_req

Interface
REQ-001 SHALL have: clk  in  1  clock; reset  in  1  synchronous, active-high reset.
REQ-002 SHALL have: in_valid  in  1; in_ready  out  1  upstream handshake.
REQ-003 SHALL have: in_load_op  in  5  one-hot lb,lh,lw,lbu,lhu; in_store_op  in  3  one-hot sb,sh,sw; in_addr  in  32; in_wdata  in  32; in_ex  in  1  upstream exception.
REQ-004 SHALL have: flush  in  1  pipeline flush; ms_allowin  in  1  downstream accept.
REQ-005 SHALL have: out_valid, out_mem_req, out_ale, out_ex  out  1 each; out_vaddr  out  32; out_rdata_vld  out  1; out_rdata  out  32  early-captured load data.
REQ-006 SHALL have: data_sram_req, data_sram_wr  out  1; data_sram_size  out  2; data_sram_wstrb  out  4; data_sram_addr, data_sram_wdata  out  32; data_sram_addr_ok, data_sram_data_ok  in  1; data_sram_rdata  in  32.
REQ-007 SHALL have: ms_data_ok  out  1  filtered data_ok for the memory stage.

Function
REQ-008 SHALL hold one instruction; in_ready = !valid | (ready_go & ms_allowin); latch inputs on in_valid & in_ready.
REQ-009 SHALL implement states IDLE, ISSUE, WAIT, PASS; latched mem op without exception -> ISSUE; latched non-mem or excepting op -> PASS; no latch -> IDLE.
REQ-010 ISSUE SHALL assert data_sram_req when !flush and live outstanding < 2; addr_ok while req high -> ready_go in that cycle; if ms_allowin low -> WAIT.
REQ-011 WAIT and PASS SHALL assert ready_go; out_valid = valid & ready_go & !flush.
REQ-012 SHALL hold request fields stable while in ISSUE until addr_ok.
REQ-013 size: byte ops 0, half ops 1, word ops 2; wr = any store op; addr = latched address.
REQ-014 wstrb: sb 0001<<addr[1:0]; sh addr[1] ? 1100 : 0011; sw 1111; loads 0000.
REQ-015 wdata: sb byte replicated x4; sh halfword replicated x2; sw unchanged.
REQ-016 SHALL count live outstanding requests (2-bit): +1 on req & addr_ok, -1 on non-discarded data_ok; both in one cycle -> unchanged.
REQ-017 On flush: state -> IDLE; discard counter += live outstanding (after same-cycle data_ok); live -> 0; no data_sram_req asserted in the flush cycle.
REQ-018 data_ok with discard counter > 0 SHALL decrement it and suppress ms_data_ok.
REQ-019 data_ok in WAIT with discard 0 and live outstanding 1 SHALL be captured: out_rdata <= rdata, out_rdata_vld <= 1, ms_data_ok suppressed; otherwise ms_data_ok = data_ok.
REQ-020 out_rdata_vld SHALL clear when the instruction passes to mem stage or on flush.
REQ-021 out_mem_req = request accepted for current instruction; out_ex = in_ex | out_ale; out_vaddr = latched address.

Reset
REQ-022 reset SHALL force state IDLE, valid 0, both counters 0, out_rdata_vld 0, out_rdata 0; all valid/req outputs 0 in that cycle.
REQ-023 reset mid-ISSUE/WAIT SHALL drop the instruction with no discard bookkeeping.

Configuration
REQ-024 Macro EXE_ALE_CHECK_EN defined: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0, set out_ale=1, enter PASS, issue no request.
REQ-025 EXE_ALE_CHECK_EN undefined: out_ale tied 0; misaligned ops issue normally.

Verification
REQ-026 sw addr 0x1000 wdata 0xDEADBEEF, addr_ok same cycle, ms_allowin 1 -> req 1 cycle, size 2, wstrb 1111, out_valid next-stage handoff.
REQ-027 sb addr 0x1003 wdata 0x5A -> wstrb 1000, wdata 0x5A5A5A5A, size 0.
REQ-028 lw addr 0x2000, addr_ok, ms_allowin 0, data_ok rdata 0x12345678 -> WAIT, out_rdata_vld 1, out_rdata 0x12345678, ms_data_ok 0.
REQ-029 lw accepted, flush before data_ok -> IDLE, discard 1; next data_ok swallowed, ms_data_ok 0, discard 0.
REQ-030 EXE_ALE_CHECK_EN, lh addr 0x3001 -> no data_sram_req, out_ale 1, out_ex 1; undefined -> req issued, out_ale 0.
REQ-031 reset asserted in ISSUE with addr_ok low -> next cycle data_sram_req 0, in_ready 1, counters 0.
